// File: rtl/col_parity_encoder.sv
// Serialises a ROWS x COLS bit frame and appends one even column-parity row.
// Data bits are echoed one cycle after acceptance; parity follows gap-free.
module col_parity_encoder #(
    parameter int ROWS = 4,
    parameter int COLS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic in_valid,
    input  logic in_bit,
    output logic en,
    output logic pin,
    output logic co,
    output logic busy,
    output logic done
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        PAR  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [COLS-1:0] r_par;
    logic            r_par_end;
    logic            r_en;
    logic            r_pin;
    logic            r_co;
    logic            r_busy;
    logic            r_done;

    function automatic logic [COLS-1:0] fold_bit(input logic [COLS-1:0] par,
                                                 input logic [CW-1:0]   idx,
                                                 input logic            b);
        logic [COLS-1:0] v;
        v      = par;
        v[idx] = v[idx] ^ b;
        return v;
    endfunction

    // Frame sequencer; outputs are registered alongside the state they belong to,
    // so done/busy line up with FIN and a separate end flag delays FIN by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_par     <= '0;
            r_par_end <= 1'b0;
            r_en      <= 1'b0;
            r_pin     <= 1'b0;
            r_co      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_en   <= 1'b0;
            r_pin  <= 1'b0;
            r_co   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= RECV;
                        r_col     <= '0;
                        r_row     <= '0;
                        r_par     <= '0;
                        r_par_end <= 1'b0;
                        r_busy    <= 1'b1;
                    end else begin
                        r_busy    <= 1'b0;
                    end
                end
                RECV: begin
                    if (in_valid) begin
                        r_en  <= 1'b1;
                        r_pin <= in_bit;
                        r_co  <= (r_col == COL_LAST);
                        r_par <= fold_bit(r_par, r_col, in_bit);
                        if (r_col == COL_LAST) begin
                            r_col <= '0;
                            if (r_row == ROW_LAST) begin
                                r_state <= PAR;
                            end else begin
                                r_row <= r_row + RW'(1);
                            end
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end else begin
                        r_col <= r_col;
                    end
                end
                PAR: begin
                    if (r_par_end) begin
                        r_state <= FIN;
                        r_done  <= 1'b1;
                    end else begin
                        r_en  <= 1'b1;
                        r_pin <= r_par[r_col];
                        r_co  <= (r_col == COL_LAST);
                        if (r_col == COL_LAST) begin
                            r_col     <= '0;
                            r_par_end <= 1'b1;
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign en   = r_en;
    assign pin  = r_pin;
    assign co   = r_co;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_col_parity_encoder.sv
// Scoreboard bench: the driver pushes expected output bits, a negedge monitor
// pops and compares them whenever en is high.
module tb_col_parity_encoder;

    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int NBITS = ROWS * COLS;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic in_valid;
    logic in_bit;
    logic en;
    logic pin;
    logic co;
    logic busy;
    logic done;

    col_parity_encoder #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .en       (en),
        .pin      (pin),
        .co       (co),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pin;
        logic co;
        logic last;
        logic par;
    } item_t;

    item_t sb[$];
    item_t mon_it;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    done_cnt = 0;
    int    en_cnt   = 0;
    int    co_cnt   = 0;
    bit    want_done = 1'b0;
    bit    want_idle = 1'b0;
    bit    par_mid   = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares presented outputs with the scoreboard head and frame rules.
    always @(negedge clk) begin
        if (!rst) begin
            want_done = 1'b0;
            want_idle = 1'b0;
            par_mid   = 1'b0;
            en_cnt    = 0;
            co_cnt    = 0;
        end else begin
            if (done) done_cnt++;
            if (want_idle) begin
                chk("busy_low_after_done", busy, 0);
                want_idle = 1'b0;
            end
            if (want_done) begin
                chk("done_after_parity", done, 1);
                chk("en_low_in_fin", en, 0);
                chk("busy_in_fin", busy, 1);
                chk("en_pulses_per_frame", en_cnt, (ROWS + 1) * COLS);
                chk("co_pulses_per_frame", co_cnt, ROWS + 1);
                en_cnt    = 0;
                co_cnt    = 0;
                want_done = 1'b0;
                want_idle = 1'b1;
            end else if (done) begin
                chk("spurious_done", done, 0);
            end
            if (par_mid) chk("parity_gapless", en, 1);
            par_mid = 1'b0;
            if (en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_en", en, 0);
                end else begin
                    mon_it = sb.pop_front();
                    chk("pin", pin, mon_it.pin);
                    chk("co", co, mon_it.co);
                    en_cnt++;
                    if (co) co_cnt++;
                    if (mon_it.last) want_done = 1'b1;
                    par_mid = mon_it.par && !mon_it.last;
                end
            end else if (pin || co) begin
                chk("pin_co_zero_when_idle", {pin, co}, 0);
            end
        end
    end

    // Rows are written with column 0 as the leftmost (MSB) character.
    function automatic logic [NBITS-1:0] pack_rows(input logic [COLS-1:0] r0,
                                                   input logic [COLS-1:0] r1,
                                                   input logic [COLS-1:0] r2,
                                                   input logic [COLS-1:0] r3);
        logic [COLS-1:0]  rows [ROWS];
        logic [NBITS-1:0] v;
        rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[r*COLS + c] = rows[r][COLS-1-c];
        return v;
    endfunction

    task automatic run_frame(input logic [NBITS-1:0] data, input bit gaps,
                             input bit poke, input int abort_after);
        bit grid [ROWS][COLS];
        int n;
        int seen;
        bit p;
        @(posedge clk); #1;
        start = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_on_start", busy, 1);
        for (int k = 0; k < NBITS; k++) grid[k / COLS][k % COLS] = data[k];
        n = (abort_after >= 0) ? abort_after : NBITS;
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_bit   = data[k];
            start    = poke && (k == 5);
            sb.push_back(item_t'{pin: data[k], co: (k % COLS == COLS - 1), last: 1'b0, par: 1'b0});
            @(posedge clk); #1;
            in_valid = 1'b0;
            start    = 1'b0;
            if (gaps) begin
                in_bit = 1'($urandom);
                @(posedge clk); #1;
            end
        end
        if (abort_after >= 0) begin
            @(negedge clk); #1;
            rst = 1'b0;
            #1;
            chk("abort_en", en, 0);
            chk("abort_pin", pin, 0);
            chk("abort_co", co, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            sb.delete();
            @(negedge clk); #1;
            rst = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            return;
        end
        for (int c = 0; c < COLS; c++) begin
            p = 1'b0;
            for (int r = 0; r < ROWS; r++) p = p ^ grid[r][c];
            sb.push_back(item_t'{pin: p, co: (c == COLS - 1), last: (c == COLS - 1), par: 1'b1});
        end
        seen = done_cnt;
        for (int i = 0; i < 3 * COLS; i++) begin
            in_valid = 1'($urandom);
            in_bit   = 1'($urandom);
            start    = poke && (i == 2);
            @(posedge clk); #1;
            start = 1'b0;
            if (done_cnt != seen) break;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (done_cnt == seen) chk("done_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    int frames = 0;

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        #2;
        chk("reset_en", en, 0);
        chk("reset_pin", pin, 0);
        chk("reset_co", co, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        #20 rst = 1'b1;

        run_frame('0, 1'b0, 1'b0, -1); frames++;
        run_frame(pack_rows(8'b11111111, 8'b00000000, 8'b00000000, 8'b00000000), 1'b0, 1'b0, -1); frames++;
        run_frame(pack_rows(8'b10000000, 8'b10000000, 8'b01000000, 8'b00000001), 1'b0, 1'b0, -1); frames++;
        run_frame(pack_rows(8'b11111111, 8'b00000000, 8'b00000000, 8'b00000000), 1'b1, 1'b0, -1); frames++;
        run_frame(pack_rows(8'b10000000, 8'b10000000, 8'b01000000, 8'b00000001), 1'b1, 1'b0, -1); frames++;
        run_frame({$urandom, $urandom} , 1'b0, 1'b0, 13);
        run_frame('1, 1'b0, 1'b0, -1); frames++;
        run_frame(NBITS'($urandom), 1'b0, 1'b1, -1); frames++;
        for (int f = 0; f < 6; f++) begin
            run_frame(NBITS'($urandom), 1'($urandom), 1'b0, -1);
            frames++;
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        chk("done_pulse_count", done_cnt, frames);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
